serial_to_parallel: RTL and testbench
=====================================

Name: serial_to_parallel

Overview:
- LSB-first serial receiver; the receiving end of the 4-bit parallel-to-serial link.
- Collects WIDTH data bits, qualified per cycle by valid_i, into a word.
- Presents the word on a valid/ready output register to downstream logic.
- Flags overrun when a completed word cannot be stored.

Parameters:
WIDTH, 4, data bits per word (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
serial_i  input  1  serial data bit, LSB first
valid_i  input  1  serial_i carries a valid bit this cycle
parallel_o  output  WIDTH  assembled word; stable while valid_o=1
valid_o  output  1  parallel_o holds an unconsumed word
ready_i  input  1  downstream accepts word when valid_o && ready_i
busy_o  output  1  word partially received (bit count != 0)
overrun_o  output  1  one-cycle pulse: completed word dropped
parity_err_o  output  1  parity flag for the word on parallel_o (see Optional Feature)

Behaviour:
- Reset (asynchronous): shift register=0, bit count=0, state=RX_IDLE, parallel_o=0, valid_o=0, busy_o=0, overrun_o=0, parity_err_o=0. Reset mid-word discards the partial word.
- FSM states:
  - RX_IDLE: count=0. A cycle with valid_i=1 captures the bit into position 0, sets count=1, and moves to RX_SHIFT.
  - RX_SHIFT: each cycle with valid_i=1 captures the bit into position count and increments count.
  - Cycles with valid_i=0 hold all state; gaps between bits are allowed.
- Word complete: on the cycle the bit at position WIDTH-1 is captured (with parity enabled, the parity bit), count returns to 0 and the state returns to RX_IDLE.
- Word transfer: the completed word loads the output register if the register is empty, or if it is being consumed that same cycle (valid_o && ready_i).
  - valid_o rises the next cycle, with parallel_o = word and bit k = k-th received bit.
- Latency: 1 cycle from the final bit to valid_o.
- Back-to-back operation: the first bit of the next word may arrive on the cycle after the final bit; no dead cycle.
- Handshake: valid_o stays high and parallel_o stays stable until the cycle with ready_i=1; valid_o clears the following cycle unless a new word loads simultaneously. ready_i is ignored while valid_o=0.
- Overrun: a word that completes while valid_o=1 and ready_i=0 is dropped. The held word is unchanged, overrun_o pulses high for 1 cycle, and reception restarts at bit 0.
- busy_o = (count != 0), combinational from the register.
- Count width: clog2(WIDTH+1) bits; never exceeds WIDTH.

Optional Feature:
- Macro S2P_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit; the frame is complete only after the parity bit.
  - parity_err_o = XOR of the data bits and the parity bit; it is registered with parallel_o and valid alongside valid_o.
  - An errored word is still delivered.
- Undefined: the frame is WIDTH bits and parity_err_o is tied to 0.

Decomposition:
- Package s2p_pkg holds:
  - rx_state_t enum {RX_IDLE, RX_SHIFT}
  - DEFAULT_WIDTH=4
  - counter-width helper function
- Sub-module s2p_hold_reg: single-entry valid/ready output register with load, consume, and the overrun-detect signal.

Test Plan (WIDTH=4):
- After reset, bits 1,0,1,1 on 4 consecutive valid cycles, ready_i=1 -> valid_o high on cycle 5, parallel_o=4'hD, high for 1 cycle.
- Bits 0,1 / valid_i low 3 cycles / bits 1,0 -> busy_o high through the gap, parallel_o=4'h6.
- Two back-to-back words 4'hA, 4'h5 with ready_i=0, then ready_i=1 -> parallel_o stays 4'hA, overrun_o pulses once on completion of the 2nd word, 4'h5 is never presented.
- Word 4'h3 with ready_i asserted on the same cycle the next word 4'hC completes -> 4'hC loads with no valid_o gap, no overrun.
- Reset asserted after 2 bits, then a full word 4'h9 -> only 4'h9 appears, no stale bits.
- With S2P_PARITY_EN: data 4'h7 plus parity 1 -> parity_err_o=0; data 4'h7 plus parity 0 -> parity_err_o=1, word still delivered.

Source files
------------

// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared types, defaults and sizing helper for serial_to_parallel
//
// Contents:
//   rx_state_t    receiver FSM state (RX_IDLE, RX_SHIFT)
//   DEFAULT_WIDTH default data bits per word
//   cnt_width()   bit-count register width, clog2(width+1)
package s2p_pkg;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_t;

   localparam int DEFAULT_WIDTH = 4;

   // Wide enough to hold every value 0..width, so the parity position
   // (index width) also fits when the parity bit is enabled.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/s2p_hold_reg.sv
// rtl/s2p_hold_reg.sv - single-entry valid/ready output register with overrun detect
//
// Ports:
//   clk, reset   clock (rising edge), asynchronous active-high reset
//   load_i       a completed word is offered this cycle
//   data_i       offered word
//   perr_i       parity flag travelling with the offered word
//   ready_i      downstream accepts the held word when valid_o && ready_i
//   data_o       held word, stable while valid_o=1
//   perr_o       parity flag of the held word
//   valid_o      register holds an unconsumed word
//   overrun_o    one-cycle pulse: an offered word found the register full
module s2p_hold_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             perr_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             perr_o,
   output logic             valid_o,
   output logic             overrun_o
);

   logic [WIDTH-1:0] data_q;
   logic             perr_q;
   logic             valid_q;
   logic             overrun_q;
   logic             can_load;

   // A slot is free if empty, or if the held word leaves on this same edge.
   assign can_load = !valid_q || ready_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q    <= '0;
         perr_q    <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= load_i && !can_load;
         if (load_i && can_load) begin
            data_q  <= data_i;
            perr_q  <= perr_i;
            valid_q <= 1'b1;
         end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign data_o    = data_q;
   assign perr_o    = perr_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - LSB-first serial receiver with valid/ready word output
//
// Build option: define S2P_PARITY_EN to expect an even-parity bit after each
// WIDTH data bits; otherwise frames are WIDTH bits and parity_err_o is 0.
//
// Ports:
//   clk, reset    clock (rising edge), asynchronous active-high reset
//   serial_i      serial data bit, LSB first
//   valid_i       serial_i carries a valid bit this cycle
//   parallel_o    assembled word, stable while valid_o=1
//   valid_o       parallel_o holds an unconsumed word
//   ready_i       downstream accepts word when valid_o && ready_i
//   busy_o        word partially received
//   overrun_o     one-cycle pulse: completed word dropped
//   parity_err_o  parity flag for the word on parallel_o
module serial_to_parallel
   import s2p_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_i,
   input  logic             valid_i,
   output logic [WIDTH-1:0] parallel_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             busy_o,
   output logic             overrun_o,
   output logic             parity_err_o
);

   localparam int CW = cnt_width(WIDTH);

   // Count value at which the final bit of a frame is captured.
`ifdef S2P_PARITY_EN
   localparam logic [CW-1:0] LAST_POS = CW'(WIDTH);
`else
   localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);
`endif

   rx_state_t        state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_c;
   logic             word_done;
   logic             perr_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RX_IDLE;
         count_q <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      shift_d   = shift_q;
      word_done = 1'b0;
      perr_c    = 1'b0;

      // Shift register with the current bit dropped into position count.
      // At the parity position no data index matches, so word_c = shift_q.
      word_c = shift_q;
      for (int k = 0; k < WIDTH; k++) begin
         if (count_q == CW'(k)) begin
            word_c[k] = serial_i;
         end
      end

      case (state_q)
         RX_IDLE: begin
            if (valid_i) begin
               shift_d = {{(WIDTH-1){1'b0}}, serial_i};
               count_d = CW'(1);
               state_d = RX_SHIFT;
            end
         end
         RX_SHIFT: begin
            if (valid_i) begin
               if (count_q == LAST_POS) begin
                  // Frame complete: offer word and restart at bit 0,
                  // whether or not the output register accepts it.
                  word_done = 1'b1;
                  shift_d   = '0;
                  count_d   = '0;
                  state_d   = RX_IDLE;
`ifdef S2P_PARITY_EN
                  perr_c    = (^shift_q) ^ serial_i;
`endif
               end else begin
                  shift_d = word_c;
                  count_d = count_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   assign busy_o = (count_q != '0);

   s2p_hold_reg #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk       (clk),
      .reset     (reset),
      .load_i    (word_done),
      .data_i    (word_c),
      .perr_i    (perr_c),
      .ready_i   (ready_i),
      .data_o    (parallel_o),
      .perr_o    (parity_err_o),
      .valid_o   (valid_o),
      .overrun_o (overrun_o)
   );

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb/tb_serial_to_parallel.sv - scoreboard testbench for serial_to_parallel (WIDTH=4)
module tb_serial_to_parallel;

   logic       clk;
   logic       reset;
   logic       serial_i;
   logic       valid_i;
   logic [3:0] parallel_o;
   logic       valid_o;
   logic       ready_i;
   logic       busy_o;
   logic       overrun_o;
   logic       parity_err_o;

   int total = 0;
   int bad   = 0;
   int ovr_cnt = 0;

   logic [4:0] exp_q[$];
   logic [4:0] obs_q[$];

   serial_to_parallel #(.WIDTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .serial_i     (serial_i),
      .valid_i      (valid_i),
      .parallel_o   (parallel_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .busy_o       (busy_o),
      .overrun_o    (overrun_o),
      .parity_err_o (parity_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every word actually handed downstream and every overrun pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (valid_o && ready_i) obs_q.push_back({parity_err_o, parallel_o});
         if (overrun_o) ovr_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bit_in(input logic b, input logic r);
      serial_i = b;
      valid_i  = 1'b1;
      ready_i  = r;
      step();
      valid_i  = 1'b0;
      serial_i = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w, input logic par);
      for (int i = 0; i < 4; i++) bit_in(w[i], ready_i);
`ifdef S2P_PARITY_EN
      bit_in(par, ready_i);
`else
      if (par === 1'bx) $display("note: parity bit unknown");
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1; serial_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      step(); step();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
      total++; if (parallel_o !== 4'h0) begin bad++; $display("FAIL reset_data got=%h want=0", parallel_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
      total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun_o); end
      total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", parity_err_o); end
      #3 reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      ready_i = 1'b1;
      bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
`ifdef S2P_PARITY_EN
      bit_in(1'b1, 1'b1);
`endif
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", valid_o); end
      exp_q.push_back({1'b0, 4'hD});
      bit_in(1'b1, 1'b1);
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", valid_o); end
      total++; if (parallel_o !== 4'hD) begin bad++; $display("FAIL basic_data got=%h want=d", parallel_o); end
      total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL basic_perr got=%b want=0", parity_err_o); end
      step();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b want=0", valid_o); end
   endtask

   task automatic test_gap();
      ready_i = 1'b1;
      bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL gap_busy cyc=%0d got=%b want=1", i, busy_o); end
      end
      exp_q.push_back({1'b0, 4'h6});
      bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
`ifdef S2P_PARITY_EN
      bit_in(1'b0, 1'b1);
`endif
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL gap_busy_end got=%b want=0", busy_o); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL gap_valid got=%b want=1", valid_o); end
      total++; if (parallel_o !== 4'h6) begin bad++; $display("FAIL gap_data got=%h want=6", parallel_o); end
      step();
   endtask

   task automatic test_overrun();
      int base;
      base = ovr_cnt;
      ready_i = 1'b0;
      exp_q.push_back({1'b0, 4'hA});
      send_word(4'hA, ^4'hA);
      send_word(4'h5, ^4'h5);
      total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", overrun_o); end
      total++; if (parallel_o !== 4'hA) begin bad++; $display("FAIL ovr_held got=%h want=a", parallel_o); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", valid_o); end
      step();
      total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL ovr_pulse_end got=%b want=0", overrun_o); end
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      step();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b want=0", valid_o); end
      total++; if (ovr_cnt - base !== 1) begin bad++; $display("FAIL ovr_count got=%0d want=1", ovr_cnt - base); end
   endtask

   task automatic test_back_to_back();
      int base;
      base = ovr_cnt;
      ready_i = 1'b0;
      exp_q.push_back({1'b0, 4'h3});
      send_word(4'h3, ^4'h3);
      exp_q.push_back({1'b0, 4'hC});
      bit_in(1'b0, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
`ifdef S2P_PARITY_EN
      bit_in(1'b1, 1'b0);
      bit_in(1'b0, 1'b1);
`else
      bit_in(1'b1, 1'b1);
`endif
      ready_i = 1'b0;
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", valid_o); end
      total++; if (parallel_o !== 4'hC) begin bad++; $display("FAIL b2b_data got=%h want=c", parallel_o); end
      total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", overrun_o); end
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      step();
      total++; if (ovr_cnt - base !== 0) begin bad++; $display("FAIL b2b_ovr_count got=%0d want=0", ovr_cnt - base); end
   endtask

   task automatic test_reset_mid();
      ready_i = 1'b1;
      bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
      #2 reset = 1'b1;
      #5;
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy_o); end
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", valid_o); end
      reset = 1'b0;
      step();
      exp_q.push_back({1'b0, 4'h9});
      send_word(4'h9, ^4'h9);
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL rstmid_word_valid got=%b want=1", valid_o); end
      total++; if (parallel_o !== 4'h9) begin bad++; $display("FAIL rstmid_data got=%h want=9", parallel_o); end
      step();
   endtask

`ifdef S2P_PARITY_EN
   task automatic test_parity();
      ready_i = 1'b1;
      exp_q.push_back({1'b0, 4'h7});
      send_word(4'h7, 1'b1);
      total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL par_good got=%b want=0", parity_err_o); end
      total++; if (parallel_o !== 4'h7) begin bad++; $display("FAIL par_good_data got=%h want=7", parallel_o); end
      step();
      exp_q.push_back({1'b1, 4'h7});
      send_word(4'h7, 1'b0);
      total++; if (parity_err_o !== 1'b1) begin bad++; $display("FAIL par_bad got=%b want=1", parity_err_o); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL par_bad_valid got=%b want=1", valid_o); end
      step();
   endtask
`endif

   task automatic test_scoreboard();
      int n;
      ready_i = 1'b1;
      step(); step();
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++; $display("FAIL sb_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         logic [4:0] o, e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL sb_word idx=%0d got=%h want=%h", i, o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
`ifdef S2P_PARITY_EN
      test_parity();
`endif
      test_scoreboard();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
